// File: rtl/dla_sched_pkg.sv
// ============================================================================
//  dla_sched_pkg : shared types for the DLA tile scheduler
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package dla_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_TL_REQ   = 3'd1,
      ST_TL_WAIT  = 3'd2,
      ST_DLA_REQ  = 3'd3,
      ST_DLA_WAIT = 3'd4,
      ST_DONE     = 3'd5,
      ST_ERR      = 3'd6
   } sched_state_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'b00,
      ERR_TL_TO  = 2'b01,
      ERR_DLA_TO = 2'b10,
      ERR_OVF    = 2'b11
   } err_code_e;

   function automatic logic state_is_busy(input sched_state_e s);
      return !((s == ST_IDLE) || (s == ST_ERR));
   endfunction

endpackage

`default_nettype wire

// File: rtl/sched_watchdog.sv
// ============================================================================
//  sched_watchdog : per-phase cycle counter; expires on the limit-th enabled cycle
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sched_watchdog #(
   parameter int TIMEOUT_W = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_i,
   input  logic                 enable_i,
   input  logic [TIMEOUT_W-1:0] limit_i,
   output logic                 expired_o
);

   logic [TIMEOUT_W-1:0] cnt_q;
   logic [TIMEOUT_W-1:0] cnt_d;
   logic [TIMEOUT_W:0]   w_cnt_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // cnt_q holds the cycles already spent, so the current cycle is cnt_q+1
   assign w_cnt_next = {1'b0, cnt_q} + 1'b1;
   assign expired_o  = enable_i && (limit_i != '0) && (w_cnt_next == {1'b0, limit_i});

endmodule

`default_nettype wire

// File: rtl/dla_tile_scheduler.sv
// ============================================================================
//  dla_tile_scheduler : per-layer sequencer between the tiling DMA and the DLA
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dla_tile_scheduler
   import dla_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int TILE_CNT_W = 16,
   parameter int TIMEOUT_W  = 20,
   parameter int MAX_TILES  = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_start,
   input  logic [TIMEOUT_W-1:0]  cfg_timeout,
   input  logic                  cfg_err_clr,
   output logic                  cfg_busy,
   output logic                  cfg_irq,
   output logic                  cfg_err,
   output logic [1:0]            cfg_err_code,
   output logic [TILE_CNT_W-1:0] tile_count,
   output logic                  tl_start,
   input  logic                  tl_finish,
   input  logic                  tl_done,
   input  logic [ADDR_WIDTH-1:0] tl_glb_addr,
   output logic                  dla_start,
   output logic [ADDR_WIDTH-1:0] dla_opsum_addr,
   input  logic                  dla_done,
   output logic                  glb_owner
);

   localparam logic [TILE_CNT_W-1:0] c_max_tiles = TILE_CNT_W'(MAX_TILES);

   sched_state_e          state_q, state_d;
   logic                  tl_start_q, tl_start_d;
   logic                  dla_start_q, dla_start_d;
   logic                  glb_owner_q, glb_owner_d;
   logic                  err_q, err_d;
   err_code_e             err_code_q, err_code_d;
   logic [TILE_CNT_W-1:0] tile_count_q, tile_count_d;
   logic [ADDR_WIDTH-1:0] opsum_addr_q, opsum_addr_d;

   logic w_wd_clear;
   logic w_wd_enable;
   logic w_wd_expired;
   logic w_ovf;
   logic w_tl_to;
   logic w_dla_to;

   assign w_wd_clear  = (state_d != state_q);
   assign w_wd_enable = (state_q == ST_TL_WAIT) || (state_q == ST_DLA_WAIT);

   sched_watchdog #(
      .TIMEOUT_W (TIMEOUT_W)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (w_wd_clear),
      .enable_i  (w_wd_enable),
      .limit_i   (cfg_timeout),
      .expired_o (w_wd_expired)
   );

   // A completion event in the expiry cycle takes priority over the timeout
   assign w_ovf    = tl_finish && !tl_done && (tile_count_q == c_max_tiles);
   assign w_tl_to  = !tl_finish && w_wd_expired;
   assign w_dla_to = !dla_done && w_wd_expired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // REQ states leave once their registered pulse has been presented, so a
   // REQ entered from a WAIT state spends one cycle switching the GLB mux first.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_start) state_d = ST_TL_REQ;
         end
         ST_TL_REQ: begin
            if (tl_start_q) state_d = ST_TL_WAIT;
         end
         ST_TL_WAIT: begin
            if (tl_finish) begin
               if (tl_done)    state_d = ST_DONE;
               else if (w_ovf) state_d = ST_ERR;
               else            state_d = ST_DLA_REQ;
            end else if (w_tl_to) begin
               state_d = ST_ERR;
            end
         end
         ST_DLA_REQ: begin
            if (dla_start_q) state_d = ST_DLA_WAIT;
         end
         ST_DLA_WAIT: begin
            if (dla_done)      state_d = ST_TL_REQ;
            else if (w_dla_to) state_d = ST_ERR;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            if (cfg_err_clr) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      tl_start_d   = 1'b0;
      dla_start_d  = 1'b0;
      glb_owner_d  = (state_d == ST_DLA_REQ) || (state_d == ST_DLA_WAIT);
      err_d        = (state_d == ST_ERR);
      err_code_d   = err_code_q;
      tile_count_d = tile_count_q;
      opsum_addr_d = opsum_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               tl_start_d   = 1'b1;
               tile_count_d = '0;
               err_code_d   = ERR_NONE;
            end
         end
         ST_TL_REQ: begin
            tl_start_d = !tl_start_q;
         end
         ST_TL_WAIT: begin
            if (tl_finish && !tl_done) opsum_addr_d = tl_glb_addr;
            if (w_ovf)        err_code_d = ERR_OVF;
            else if (w_tl_to) err_code_d = ERR_TL_TO;
         end
         ST_DLA_REQ: begin
            dla_start_d = !dla_start_q;
         end
         ST_DLA_WAIT: begin
            if (dla_done) begin
               if (tile_count_q != '1) tile_count_d = tile_count_q + 1'b1;
            end else if (w_dla_to) begin
               err_code_d = ERR_DLA_TO;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tl_start_q   <= 1'b0;
         dla_start_q  <= 1'b0;
         glb_owner_q  <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= ERR_NONE;
         tile_count_q <= '0;
         opsum_addr_q <= '0;
      end else begin
         tl_start_q   <= tl_start_d;
         dla_start_q  <= dla_start_d;
         glb_owner_q  <= glb_owner_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
         tile_count_q <= tile_count_d;
         opsum_addr_q <= opsum_addr_d;
      end
   end

   assign cfg_busy       = state_is_busy(state_q);
   assign cfg_irq        = (state_q == ST_DONE);
   assign cfg_err        = err_q;
   assign cfg_err_code   = err_code_q;
   assign tile_count     = tile_count_q;
   assign tl_start       = tl_start_q;
   assign dla_start      = dla_start_q;
   assign dla_opsum_addr = opsum_addr_q;
   assign glb_owner      = glb_owner_q;

endmodule

`default_nettype wire

// File: tb/tb_dla_tile_scheduler.sv
// ============================================================================
//  tb_dla_tile_scheduler : directed scoreboard bench for dla_tile_scheduler
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dla_tile_scheduler;

   localparam int AW = 32;
   localparam int CW = 16;
   localparam int TW = 20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_start;
   logic [TW-1:0] cfg_timeout;
   logic          cfg_err_clr;
   logic          cfg_busy;
   logic          cfg_irq;
   logic          cfg_err;
   logic [1:0]    cfg_err_code;
   logic [CW-1:0] tile_count;
   logic          tl_start;
   logic          tl_finish;
   logic          tl_done;
   logic [AW-1:0] tl_glb_addr;
   logic          dla_start;
   logic [AW-1:0] dla_opsum_addr;
   logic          dla_done;
   logic          glb_owner;

   dla_tile_scheduler #(
      .ADDR_WIDTH (AW),
      .TILE_CNT_W (CW),
      .TIMEOUT_W  (TW),
      .MAX_TILES  (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_start      (cfg_start),
      .cfg_timeout    (cfg_timeout),
      .cfg_err_clr    (cfg_err_clr),
      .cfg_busy       (cfg_busy),
      .cfg_irq        (cfg_irq),
      .cfg_err        (cfg_err),
      .cfg_err_code   (cfg_err_code),
      .tile_count     (tile_count),
      .tl_start       (tl_start),
      .tl_finish      (tl_finish),
      .tl_done        (tl_done),
      .tl_glb_addr    (tl_glb_addr),
      .dla_start      (dla_start),
      .dla_opsum_addr (dla_opsum_addr),
      .dla_done       (dla_done),
      .glb_owner      (glb_owner)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;
   int n_tl_start  = 0;
   int n_dla_start = 0;
   int n_irq       = 0;
   logic err_prev  = 1'b0;

   logic [AW-1:0] exp_addr_q[$];
   logic [CW-1:0] exp_cnt_q[$];
   logic [1:0]    exp_code_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s: event seen, none expected", name);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a result
   always @(negedge clk) begin
      if (!rst_n) begin
         err_prev = 1'b0;
      end else begin
         if (tl_start) n_tl_start++;
         if (dla_start) begin
            n_dla_start++;
            if (exp_addr_q.size() == 0) flag("unexpected_dla_start");
            else check("dla_opsum_addr", dla_opsum_addr, exp_addr_q.pop_front());
         end
         if (cfg_irq) begin
            n_irq++;
            if (exp_cnt_q.size() == 0) flag("unexpected_irq");
            else check("irq_tile_count", tile_count, exp_cnt_q.pop_front());
         end
         if (cfg_err && !err_prev) begin
            if (exp_code_q.size() == 0) flag("unexpected_err");
            else check("err_code", cfg_err_code, exp_code_q.pop_front());
            check("err_glb_owner", glb_owner, 0);
         end
         err_prev = cfg_err;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_layer();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("start_to_tl_start", tl_start, 1);
      check("start_count_clear", tile_count, 0);
      check("start_code_clear", cfg_err_code, 0);
   endtask

   // Entered at the negedge showing tl_start; done_delay<0 withholds dla_done
   task automatic run_tile(input logic [AW-1:0] addr, input int done_delay, input bit poke);
      tick();
      tl_finish   = 1'b1;
      tl_done     = 1'b0;
      tl_glb_addr = addr;
      exp_addr_q.push_back(addr);
      tick();
      tl_finish = 1'b0;
      check("owner_in_dla_req", glb_owner, 1);
      check("no_early_dla_start", dla_start, 0);
      tick();
      check("finish_to_dla_start", dla_start, 1);
      if (done_delay < 0) return;
      if (poke) begin
         tick();
         cfg_start = 1'b1;
         tick();
         cfg_start = 1'b0;
         tick(done_delay - 2);
      end else begin
         tick(done_delay);
      end
      dla_done = 1'b1;
      tick();
      dla_done = 1'b0;
      check("handback_gap", tl_start, 0);
      check("owner_released", glb_owner, 0);
      check("no_err_at_handback", cfg_err, 0);
      tick();
      check("done_to_tl_start", tl_start, 1);
   endtask

   task automatic finish_layer(input logic [CW-1:0] cnt);
      tick();
      tl_finish = 1'b1;
      tl_done   = 1'b1;
      exp_cnt_q.push_back(cnt);
      tick();
      tl_finish = 1'b0;
      tl_done   = 1'b0;
      check("irq_on_done", cfg_irq, 1);
      tick();
      check("irq_single_cycle", cfg_irq, 0);
      check("busy_after_done", cfg_busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      int snap;
      rst_n       = 1'b0;
      cfg_start   = 1'b0;
      cfg_timeout = '0;
      cfg_err_clr = 1'b0;
      tl_finish   = 1'b0;
      tl_done     = 1'b0;
      tl_glb_addr = '0;
      dla_done    = 1'b0;

      // Reset state
      tick(2);
      check("rst_busy", cfg_busy, 0);
      check("rst_irq", cfg_irq, 0);
      check("rst_err", cfg_err, 0);
      check("rst_code", cfg_err_code, 0);
      check("rst_count", tile_count, 0);
      check("rst_tl_start", tl_start, 0);
      check("rst_dla_start", dla_start, 0);
      check("rst_addr", dla_opsum_addr, 0);
      check("rst_owner", glb_owner, 0);
      rst_n = 1'b1;
      tick(5);
      check("idle_no_tl_start", n_tl_start, 0);
      check("idle_not_busy", cfg_busy, 0);

      // Three-tile layer, done on the third finish
      start_layer();
      check("busy_in_layer", cfg_busy, 1);
      run_tile(32'h100, 3, 1'b0);
      run_tile(32'h200, 3, 1'b0);
      finish_layer(16'd2);
      check("count_holds", tile_count, 2);

      // DLA watchdog timeout
      cfg_timeout = 20'd50;
      start_layer();
      run_tile(32'h300, -1, 1'b0);
      exp_code_q.push_back(2'b10);
      k = 0;
      while (!cfg_err && k < 200) begin
         tick();
         k++;
      end
      check("timeout_cycle", k, 51);
      check("err_not_busy", cfg_busy, 0);
      tick(3);
      check("err_no_tl_start", tl_start, 0);
      cfg_err_clr = 1'b1;
      tick();
      cfg_err_clr = 1'b0;
      check("err_cleared", cfg_err, 0);
      check("code_holds", cfg_err_code, 2);
      check("clr_idle", cfg_busy, 0);

      // dla_done coincides with watchdog expiry
      start_layer();
      run_tile(32'h400, 50, 1'b0);
      finish_layer(16'd1);

      // cfg_start during DLA_WAIT is dropped
      cfg_timeout = '0;
      start_layer();
      run_tile(32'h500, 4, 1'b1);
      finish_layer(16'd1);

      // Reset mid TL_WAIT aborts with no irq
      start_layer();
      tick();
      snap  = n_irq;
      rst_n = 1'b0;
      tick();
      check("abort_busy", cfg_busy, 0);
      check("abort_count", tile_count, 0);
      rst_n = 1'b1;
      tick(4);
      check("abort_no_irq", n_irq, snap);
      check("abort_idle", cfg_busy, 0);

      // Overflow with MAX_TILES=2
      start_layer();
      run_tile(32'h600, 2, 1'b0);
      run_tile(32'h700, 2, 1'b0);
      tick();
      snap        = n_dla_start;
      tl_finish   = 1'b1;
      tl_done     = 1'b0;
      tl_glb_addr = 32'h800;
      exp_code_q.push_back(2'b11);
      tick();
      tl_finish = 1'b0;
      check("ovf_err", cfg_err, 1);
      check("ovf_count", tile_count, 2);
      tick(4);
      check("ovf_no_dla_start", n_dla_start, snap);
      cfg_err_clr = 1'b1;
      tick();
      cfg_err_clr = 1'b0;
      check("ovf_cleared", cfg_err, 0);
      tick(2);

      check("leftover_addr", exp_addr_q.size(), 0);
      check("leftover_cnt", exp_cnt_q.size(), 0);
      check("leftover_code", exp_code_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
